// File: rtl/alu_seq_pkg.sv
// Shared constants, state encoding and operand-source helpers for alu_sequencer.
package alu_seq_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_XOR  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_NOTA = 4'h5;
    localparam logic [3:0] OP_NAND = 4'h6;
    localparam logic [3:0] OP_NOR  = 4'h7;
    localparam logic [3:0] OP_SUB  = 4'h8;
    localparam logic [3:0] OP_INC  = 4'h9;
    localparam logic [3:0] OP_NEG  = 4'hA;

    localparam logic [2:0] ALU_IDLE = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_XOR  = 3'd2;
    localparam logic [2:0] ALU_AND  = 3'd3;
    localparam logic [2:0] ALU_OR   = 3'd4;
    localparam logic [2:0] ALU_NOTA = 3'd5;
    localparam logic [2:0] ALU_NAND = 3'd6;
    localparam logic [2:0] ALU_NOR  = 3'd7;

    typedef enum logic [1:0] {IDLE, EXEC, RD, DONE} state_t;

    typedef enum logic [2:0] {SRC_A, SRC_B, SRC_T, SRC_ZERO, SRC_ONE} src_sel_t;

    function automatic logic [1:0] op_passes(input logic [3:0] op);
        if (op == OP_SUB)
            return 2'd3;
        else if (op == OP_NEG)
            return 2'd2;
        else if (op >= OP_ADD && op <= OP_INC)
            return 2'd1;
        else
            return 2'd0;
    endfunction

    function automatic logic op_legal(input logic [3:0] op);
        return op <= OP_NEG;
    endfunction

    function automatic logic [15:0] src_value(input src_sel_t sel, input logic [15:0] a,
                                              input logic [15:0] b, input logic [15:0] t);
        case (sel)
            SRC_A:   return a;
            SRC_B:   return b;
            SRC_T:   return t;
            SRC_ONE: return 16'd1;
            default: return 16'd0;
        endcase
    endfunction

endpackage

// File: rtl/alu.sv
// Registered 16-bit ALU: result appears on r one cycle after a/b/ctrl are applied.
module alu (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [2:0]  ctrl,
    output logic [15:0] r
);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r <= '0;
        end else begin
            case (ctrl)
                3'd1:    r <= a + b;
                3'd2:    r <= a ^ b;
                3'd3:    r <= a & b;
                3'd4:    r <= a | b;
                3'd5:    r <= ~a;
                3'd6:    r <= ~(a & b);
                3'd7:    r <= ~(a | b);
                default: r <= '0;
            endcase
        end
    end
endmodule

// File: rtl/alu_seq_decode.sv
// Per-pass operand selection and ALU control for each opcode; purely combinational.
module alu_seq_decode
    import alu_seq_pkg::*;
(
    input  logic [3:0] opcode,
    input  logic [1:0] pass,
    output logic [1:0] pass_count,
    output logic       legal,
    output src_sel_t   sel_a,
    output src_sel_t   sel_b,
    output logic [2:0] ctrl
);
    always_comb begin
        pass_count = op_passes(opcode);
        legal      = op_legal(opcode);
        sel_a      = SRC_ZERO;
        sel_b      = SRC_ZERO;
        ctrl       = ALU_IDLE;
        case (opcode)
            OP_ADD, OP_XOR, OP_AND, OP_OR, OP_NOTA, OP_NAND, OP_NOR: begin
                if (pass == 2'd0) begin
                    sel_a = SRC_A;
                    sel_b = SRC_B;
                    ctrl  = opcode[2:0];
                end
            end
            // A - B = ~B + A + 1, built from NOTA then two ADDs
            OP_SUB: begin
                case (pass)
                    2'd0: begin sel_a = SRC_B; sel_b = SRC_ZERO; ctrl = ALU_NOTA; end
                    2'd1: begin sel_a = SRC_A; sel_b = SRC_T;    ctrl = ALU_ADD;  end
                    2'd2: begin sel_a = SRC_T; sel_b = SRC_ONE;  ctrl = ALU_ADD;  end
                    default: ;
                endcase
            end
            OP_INC: begin
                if (pass == 2'd0) begin
                    sel_a = SRC_A;
                    sel_b = SRC_ONE;
                    ctrl  = ALU_ADD;
                end
            end
            OP_NEG: begin
                case (pass)
                    2'd0: begin sel_a = SRC_A; sel_b = SRC_ZERO; ctrl = ALU_NOTA; end
                    2'd1: begin sel_a = SRC_T; sel_b = SRC_ONE;  ctrl = ALU_ADD;  end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/alu_sequencer.sv
// Issues one instruction as a sequence of ALU passes and returns the final result.
// state | meaning
// IDLE  | ready for an instruction
// EXEC  | drive pass k onto the ALU inputs
// RD    | ALU result of pass k is on alu_r
// DONE  | result offered until res_ready
module alu_sequencer
    import alu_seq_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] instr,
    input  logic [15:0] op_a,
    input  logic [15:0] op_b,
    input  logic        instr_valid,
    output logic        instr_ready,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [2:0]  alu_ctrl,
    input  logic [15:0] alu_r,
    output logic [15:0] res,
    output logic        res_zero,
    output logic        res_err,
    output logic        res_valid,
    input  logic        res_ready
);
    state_t      state, state_nxt;
    logic [3:0]  opcode;
    logic [15:0] lat_a, lat_b, t;
    logic [1:0]  pass, pass_inc;
    logic [3:0]  dec_op;
    logic [1:0]  pass_count;
    logic        legal, last_pass;
    src_sel_t    sel_a, sel_b;
    logic [2:0]  dec_ctrl;
    logic        unused_instr_bits;

    assign unused_instr_bits = ^instr[11:0];

    // In IDLE the decoder looks at the offered opcode so zero-pass ops can skip EXEC.
    assign dec_op    = (state == IDLE) ? instr[15:12] : opcode;
    assign pass_inc  = pass + 2'd1;
    assign last_pass = (pass_inc == pass_count);

    alu_seq_decode u_decode (
        .opcode     (dec_op),
        .pass       (pass),
        .pass_count (pass_count),
        .legal      (legal),
        .sel_a      (sel_a),
        .sel_b      (sel_b),
        .ctrl       (dec_ctrl)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            opcode   <= '0;
            lat_a    <= '0;
            lat_b    <= '0;
            t        <= '0;
            pass     <= '0;
            res      <= '0;
            res_zero <= 1'b0;
            res_err  <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (instr_valid) begin
                        opcode <= instr[15:12];
                        lat_a  <= op_a;
                        lat_b  <= op_b;
                        pass   <= '0;
                        t      <= '0;
                        if (pass_count == 2'd0) begin
                            res      <= '0;
                            res_zero <= 1'b1;
                            res_err  <= ~legal;
                        end
                    end
                end
                RD: begin
                    if (last_pass) begin
                        res      <= alu_r;
                        res_zero <= (alu_r == 16'd0);
                        res_err  <= 1'b0;
                    end else begin
                        t    <= alu_r;
                        pass <= pass_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt   = state;
        instr_ready = 1'b0;
        res_valid   = 1'b0;
        alu_a       = '0;
        alu_b       = '0;
        alu_ctrl    = ALU_IDLE;
        case (state)
            IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid)
                    state_nxt = (pass_count == 2'd0) ? DONE : EXEC;
            end
            EXEC: begin
                alu_a     = src_value(sel_a, lat_a, lat_b, t);
                alu_b     = src_value(sel_b, lat_a, lat_b, t);
                alu_ctrl  = dec_ctrl;
                state_nxt = RD;
            end
            RD: begin
                state_nxt = last_pass ? DONE : EXEC;
            end
            DONE: begin
                res_valid = 1'b1;
                if (res_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule
